// File: rtl/xor_cipher_pkg.sv
// Shared state encoding and key-path constants for the XOR cipher key loader.
package xor_cipher_pkg;

   localparam int KEY_W     = 32;
   localparam bit MSB_FIRST = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      VERIFY = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/xor_key_piso.sv
// Loadable M-bit parallel-in/serial-out shift register. The bit shifted off the
// serial end can be fed back into the vacated end (recirc) instead of a zero.
module xor_key_piso
   import xor_cipher_pkg::*;
#(
   parameter int M = KEY_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic         recirc,
   input  logic [M-1:0] din,
   output logic         msb
);

   logic [M-1:0] sreg_q;
   logic [M-1:0] sreg_d;
   logic [M-1:0] shifted;

   generate
      for (genvar gi = 0; gi < M; gi++) begin : g_bit
         if (MSB_FIRST) begin : g_left
            if (gi == 0) begin : g_fill
               assign shifted[gi] = recirc & sreg_q[M-1];
            end else begin : g_move
               assign shifted[gi] = sreg_q[gi-1];
            end
         end else begin : g_right
            if (gi == M-1) begin : g_fill
               assign shifted[gi] = recirc & sreg_q[0];
            end else begin : g_move
               assign shifted[gi] = sreg_q[gi+1];
            end
         end
      end
   endgenerate

   always_comb begin
      sreg_d = sreg_q;
      if (load) begin
         sreg_d = din;
      end else if (shift) begin
         sreg_d = shifted;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg_q <= '0;
      end else begin
         sreg_q <= sreg_d;
      end
   end

   assign msb = MSB_FIRST ? sreg_q[M-1] : sreg_q[0];

endmodule

// File: rtl/xor_key_loader.sv
// Drives the cipher's serial key chain from an M-bit key word, MSB first.
// Define XOR_KEY_LOADER_VERIFY_EN to add a second pass that checks the chain tail.
module xor_key_loader
   import xor_cipher_pkg::*;
#(
   parameter int M     = KEY_W,
   parameter int CNT_W = $clog2(M)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [M-1:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   output logic         cfg_en,
   output logic         cfg_o,
   input  logic         cfg_ret,
   output logic         busy,
   output logic         done,
   output logic         err
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             key_ready_q, key_ready_d;
   logic             cfg_en_q, cfg_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             accept, last_bit;
   logic             load, shift, recirc, msb;

   assign accept   = key_valid && key_ready_q;
   assign last_bit = (cnt_q == CNT_W'(M - 1));

   // The serial output is the shift register MSB itself; the register drains
   // to zero on the final pass, so cfg_o is already 0 whenever cfg_en is low.
   xor_key_piso #(.M(M)) u_piso (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .shift  (shift),
      .recirc (recirc),
      .din    (key_in),
      .msb    (msb)
   );

`ifdef XOR_KEY_LOADER_VERIFY_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      shift   = 1'b0;
      recirc  = 1'b0;
`ifdef XOR_KEY_LOADER_VERIFY_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = SHIFT;
`ifdef XOR_KEY_LOADER_VERIFY_EN
               err_d   = 1'b0;
`endif
            end
         end
         SHIFT: begin
            shift = 1'b1;
`ifdef XOR_KEY_LOADER_VERIFY_EN
            recirc = 1'b1;
`endif
            if (last_bit) begin
               cnt_d = '0;
`ifdef XOR_KEY_LOADER_VERIFY_EN
               state_d = VERIFY;
`else
               state_d = DONE;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef XOR_KEY_LOADER_VERIFY_EN
         VERIFY: begin
            // Tail now returns the bit written first on the previous pass.
            shift = 1'b1;
            if (cfg_ret != msb) begin
               err_d = 1'b1;
            end
            if (last_bit) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      key_ready_d = (state_d == IDLE);
      cfg_en_d    = (state_d == SHIFT) || (state_d == VERIFY);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         key_ready_q <= 1'b0;
         cfg_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         key_ready_q <= key_ready_d;
         cfg_en_q    <= cfg_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

`ifdef XOR_KEY_LOADER_VERIFY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_cfg_ret;
   assign unused_cfg_ret = cfg_ret;
   assign err            = 1'b0;
`endif

   assign key_ready = key_ready_q;
   assign cfg_en    = cfg_en_q;
   assign cfg_o     = msb;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_xor_key_loader.sv
// Directed bench for xor_key_loader with a serial-stream scoreboard.
// Define XOR_KEY_LOADER_VERIFY_EN to also exercise the chain readback check.
module tb_xor_key_loader;

   localparam int M = 32;
`ifdef XOR_KEY_LOADER_VERIFY_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif
   localparam int LOAD_LEN = PASSES * M;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [M-1:0] key_in = '0;
   logic         key_valid = 1'b0;
   logic         key_ready;
   logic         cfg_en;
   logic         cfg_o;
   logic         cfg_ret;
   logic         busy;
   logic         done;
   logic         err;

   int vectors     = 0;
   int miscompares = 0;
   logic exp_q[$];

   always #5 clk = ~clk;

   xor_key_loader #(.M(M)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .cfg_en    (cfg_en),
      .cfg_o     (cfg_o),
      .cfg_ret   (cfg_ret),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

`ifdef XOR_KEY_LOADER_VERIFY_EN
   // Behavioural cipher chain: shifts toward the tail on every enabled edge.
   logic [M-1:0] chain = '0;
   bit           stuck7 = 1'b0;
   always @(posedge clk) begin
      logic [M-1:0] nxt;
      if (cfg_en === 1'b1) begin
         nxt = {chain[M-2:0], cfg_o};
         if (stuck7) nxt[7] = 1'b0;
         chain <= nxt;
      end
   end
   assign cfg_ret = chain[M-1];
`else
   assign cfg_ret = 1'b0;
`endif

   // On each handshake the expected serial stream is queued MSB first.
   always @(posedge clk) begin
      if (rst === 1'b1 && key_valid === 1'b1 && key_ready === 1'b1) begin
         for (int p = 0; p < PASSES; p++) begin
            for (int i = M - 1; i >= 0; i--) begin
               exp_q.push_back(key_in[i]);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic exp_bit;
      if (rst === 1'b1) begin
         vectors++;
         if (cfg_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               assert (exp_q.size() != 0) else begin
                  miscompares++;
                  $error("FAIL cfg_stream: observed cfg_en=1, expected no pending key bits");
               end
            end else begin
               exp_bit = exp_q.pop_front();
               assert (cfg_o === exp_bit) else begin
                  miscompares++;
                  $error("FAIL cfg_bit: observed %b, expected %b (%0d bits left)", cfg_o, exp_bit, exp_q.size());
               end
            end
         end else begin
            assert (cfg_o === 1'b0) else begin
               miscompares++;
               $error("FAIL cfg_o_idle: observed %b, expected 0 while cfg_en=0", cfg_o);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
      $display("check %-16s observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Caller is mid-cycle inside a cycle with key_ready=1.
   task automatic start_load(input logic [M-1:0] key);
      key_in    = key;
      key_valid = 1'b1;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
   endtask

   // Entered #1 after the handshake edge; leaves #1 into the ready cycle.
   task automatic follow_load(input string tag, input logic exp_err);
      int n;
      n = 0;
      check({tag, "_en_first"}, {31'b0, cfg_en}, 32'd1);
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      while (cfg_en === 1'b1 && n < 4 * M) begin
         n++;
         @(posedge clk);
         #1;
      end
      check({tag, "_len"}, n, LOAD_LEN);
      check({tag, "_done"}, {31'b0, done}, 32'd1);
      check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
      check({tag, "_rdy_done"}, {31'b0, key_ready}, 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_done_clr"}, {31'b0, done}, 32'd0);
      check({tag, "_rdy_back"}, {31'b0, key_ready}, 32'd1);
      check({tag, "_gap_en"}, {31'b0, cfg_en}, 32'd0);
      check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      // Reset held for three cycles, then released away from the clock edge.
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'b0, key_ready}, 32'd0);
      check("rst_cfg_en", {31'b0, cfg_en}, 32'd0);
      check("rst_cfg_o", {31'b0, cfg_o}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("idle_ready", {31'b0, key_ready}, 32'd1);
      check("idle_cfg_en", {31'b0, cfg_en}, 32'd0);
      check("idle_busy", {31'b0, busy}, 32'd0);
      check("idle_err", {31'b0, err}, 32'd0);

      // Basic load with a single-cycle valid.
      start_load(32'hDEAD_BEEF);
      check("basic_rdy_low", {31'b0, key_ready}, 32'd0);
      follow_load("basic", 1'b0);

      // Back-to-back with valid held high across both loads.
      key_in    = 32'h0000_0001;
      key_valid = 1'b1;
      @(posedge clk);
      #1;
      key_in = 32'hFFFF_FFFF;
      follow_load("b2b1", 1'b0);
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      follow_load("b2b2", 1'b0);

      // Reset asserted in the middle of shift cycle 10.
      start_load(32'h1234_5678);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b0;
      exp_q.delete();
      #1;
      check("mrst_cfg_en", {31'b0, cfg_en}, 32'd0);
      check("mrst_cfg_o", {31'b0, cfg_o}, 32'd0);
      check("mrst_busy", {31'b0, busy}, 32'd0);
      check("mrst_done", {31'b0, done}, 32'd0);
      check("mrst_ready", {31'b0, key_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("mrst_hold_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mrst_rel_ready", {31'b0, key_ready}, 32'd1);
      check("mrst_rel_busy", {31'b0, busy}, 32'd0);
      check("mrst_rel_done", {31'b0, done}, 32'd0);
      @(posedge clk);
      #1;
      check("mrst_rel_en", {31'b0, cfg_en}, 32'd0);
      check("mrst_rel_done2", {31'b0, done}, 32'd0);

`ifdef XOR_KEY_LOADER_VERIFY_EN
      // Healthy chain: readback matches, chain left holding the key.
      start_load(32'hA5A5_A5A5);
      follow_load("vpass", 1'b0);
      check("vpass_chain", chain, 32'hA5A5_A5A5);

      // Bit 7 stuck at 0: mismatch must be flagged and stay sticky.
      stuck7 = 1'b1;
      start_load(32'hFFFF_FFFF);
      follow_load("vfail", 1'b1);
      check("vfail_sticky", {31'b0, err}, 32'd1);
      stuck7 = 1'b0;
      start_load(32'h0F0F_1234);
      check("vclr_accept", {31'b0, err}, 32'd0);
      follow_load("vclr", 1'b0);
      check("vclr_chain", chain, 32'h0F0F_1234);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
